// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants (glyph table, blank code, index width)
package seg_pkg;
  localparam int SEG_IDX_W = 3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [15:0][7:0] SEG_GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: nibble + decimal point + enable to active-low segment byte
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       en,
  output logic [7:0] seg
);
  assign seg = en ? {~dp, SEG_GLYPH[nib][6:0]} : SEG_BLANK;
endmodule

// File: rtl/display_scan.sv
// display_scan: 8-digit seven-segment scan controller; SCAN_FRAME_LATCH_EN enables per-frame input shadowing
module display_scan
  import seg_pkg::*;
#(
  parameter int DIV_CNT = 100000,
  parameter int DIGITS  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [31:0]          DATA,
  input  logic [7:0]           DP,
  input  logic [7:0]           DIGIT_EN,
  output logic [SEG_IDX_W-1:0] NUM,
  output logic [7:0]           SEG,
  output logic                 FRAME
);
  localparam int CW = DIV_CNT > 1 ? $clog2(DIV_CNT) : 1;
  logic [CW-1:0] cnt;
  logic [SEG_IDX_W-1:0] num_next;
  logic tick, wrap;
  logic [31:0] data_v;
  logic [7:0] dp_v, en_v, seg_next;
  assign tick = cnt == CW'(DIV_CNT - 1);
  assign wrap = tick && NUM == SEG_IDX_W'(DIGITS - 1);
  assign num_next = wrap ? '0 : tick ? NUM + 1'b1 : NUM;
  // prescaler, digit index, wrap pulse and segment bus decoded from the next index
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt   <= '0;
      NUM   <= '0;
      FRAME <= 1'b0;
      SEG   <= SEG_BLANK;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      NUM   <= num_next;
      FRAME <= wrap;
      SEG   <= seg_next;
    end
  end
`ifdef SCAN_FRAME_LATCH_EN
  logic [31:0] data_s;
  logic [7:0] dp_s, en_s;
  logic first, load;
  assign load   = wrap || first;
  assign data_v = load ? DATA : data_s;
  assign dp_v   = load ? DP : dp_s;
  assign en_v   = load ? DIGIT_EN : en_s;
  // shadow copies refresh at each frame start and on the first edge out of reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      data_s <= '0;
      dp_s   <= '0;
      en_s   <= '0;
      first  <= 1'b1;
    end else begin
      data_s <= data_v;
      dp_s   <= dp_v;
      en_s   <= en_v;
      first  <= 1'b0;
    end
  end
`else
  assign data_v = DATA;
  assign dp_v   = DP;
  assign en_v   = DIGIT_EN;
`endif
  hex_to_seg u_dec (
    .nib(data_v[4*num_next +: 4]),
    .dp (dp_v[num_next]),
    .en (en_v[num_next]),
    .seg(seg_next)
  );
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: scoreboard bench for display_scan against an arithmetic scan model
module tb_display_scan;
  typedef struct packed {
    logic [2:0] num;
    logic [7:0] seg;
    logic       frame;
  } exp_t;
  localparam logic [7:0] GL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                     8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] data = 32'h76543210;
  logic [7:0] dp = 8'h00, en = 8'hFF;
  logic [2:0] num8, num3;
  logic [7:0] seg8, seg3;
  logic frame8, frame3;
  exp_t q8[$], q3[$];
  int total = 0, bad = 0;
  int n8 = 0, n3 = 0;
  logic [31:0] sd8 = '0, sd3 = '0;
  logic [7:0] sp8 = '0, sp3 = '0, se8 = '0, se3 = '0;

  display_scan #(.DIV_CNT(4), .DIGITS(8)) u8 (
    .CLK(clk), .RST_N(rst_n), .DATA(data), .DP(dp), .DIGIT_EN(en),
    .NUM(num8), .SEG(seg8), .FRAME(frame8)
  );
  display_scan #(.DIV_CNT(1), .DIGITS(3)) u3 (
    .CLK(clk), .RST_N(rst_n), .DATA(data), .DP(dp), .DIGIT_EN(en),
    .NUM(num3), .SEG(seg3), .FRAME(frame3)
  );

  initial forever #5 clk = ~clk;

  // n = edges since reset with RST_N high; digit = (n / dwell) mod digits
  function automatic exp_t model(int n, int d, int g, logic [31:0] dt, logic [7:0] p, logic [7:0] e);
    exp_t r;
    int i;
    i = (n / d) % g;
    r.num = 3'(i);
    r.frame = n > 0 && n % (d * g) == 0;
    r.seg = 8'hFF;
    if (n > 0 && e[i]) r.seg = {~p[i], GL[dt[4*i +: 4]][6:0]};
    return r;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      n8 = 0;
      n3 = 0;
    end else begin
      n8++;
      n3++;
    end
`ifdef SCAN_FRAME_LATCH_EN
    if (n8 == 1 || (n8 > 0 && n8 % 32 == 0)) begin sd8 = data; sp8 = dp; se8 = en; end
    if (n3 == 1 || (n3 > 0 && n3 % 3 == 0)) begin sd3 = data; sp3 = dp; se3 = en; end
`else
    sd8 = data; sp8 = dp; se8 = en;
    sd3 = data; sp3 = dp; se3 = en;
`endif
    q8.push_back(model(n8, 4, 8, sd8, sp8, se8));
    q3.push_back(model(n3, 1, 3, sd3, sp3, se3));
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk("num8", 8'(num8), 8'(e.num));
      chk("seg8", seg8, e.seg);
      chk("frame8", 8'(frame8), 8'(e.frame));
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("num3", 8'(num3), 8'(e.num));
      chk("seg3", seg3, e.seg);
      chk("frame3", 8'(frame3), 8'(e.frame));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 data = 32'hFEDCBA98; en = 8'b1111_1101; dp = 8'b0000_0001;
    repeat (40) @(posedge clk);
    #1 data = 32'h0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (13) @(posedge clk);
    #1 data = 32'h11111111;
    repeat (30) @(posedge clk);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 5) == 0) data = $urandom;
      if ($urandom_range(0, 7) == 0) dp = 8'($urandom);
      if ($urandom_range(0, 7) == 0) en = 8'($urandom);
      rst_n = $urandom_range(0, 59) != 0;
    end
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q8.size() != 0 || q3.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d want=0/0", q8.size(), q3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
